alu_ctrl_seq: RTL
=================

Name: alu_ctrl_seq

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Accepts one decoded instruction field set per transaction and produces a registered alu_control code.
- Sequences multi-cycle operations (MULS) so the ALU is held busy for a parametrised number of cycles.
- Sits between the instruction decode stage and the ALU datapath; flags undefined R-type encodings.

Parameters:
- CTRL_W, 4, width of alu_control; must be >= 4.
- MUL_CYCLES, 3, cycles MULS occupies the ALU; legal range 1..15.
- CNT_W, 4, width of internal cycle counter; must hold MUL_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept fields this cycle.
- alu_opcode  in  2  00 load, 01 branch, 10 R-type, 11 reserved.
- func7  in  1  R-type function bit 7.
- func3  in  3  R-type function bits.
- alu_start  out  1  one-cycle pulse: ALU begins operation.
- alu_busy  out  1  ALU occupied by current operation.
- out_valid  out  1  alu_control result complete.
- out_ready  in  1  downstream accepts result.
- alu_control  out  CTRL_W  registered control code, zero-extended.
- illegal  out  1  registered; current op was an undefined encoding.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; alu_start=0, alu_busy=0, out_valid=0, alu_control=0, illegal=0; counter=0. Reset mid-operation abandons the op with no output.
- Decode mapping:
  - opcode 00 -> 0; opcode 01 -> 1.
  - opcode 10, {func7,func3}: 0000 ADCS->0, 1000 ADD->1, 0001 SBCS->2, 1001 SUBS->3, 1010 RSBS->4, 1011 MULS->5, 0111 ANDS->6, 0110 ORRS->7, 1111 CMP->8.
  - Other R-type codes -> 0 with illegal=1.
  - opcode 11 -> 0 with illegal=1.
- Accept: in_valid && in_ready at edge N. alu_control and illegal are loaded at N; alu_start=1 for cycle N+1 only.
- States:
  - IDLE: in_ready=1. Accept -> EXEC; counter = (MULS ? MUL_CYCLES-1 : 0).
  - EXEC: alu_busy=1, in_ready=0. If counter==0 -> DONE, else counter decrements.
  - DONE: out_valid=1, alu_busy=1. If out_ready: out_valid drops next cycle; in_ready=out_ready, so a new accept in the same cycle -> EXEC (back-to-back), else -> IDLE. If !out_ready: stay, with alu_control/illegal held stable.
- Latency from accept edge N:
  - Single-cycle op: out_valid at N+2.
  - MULS: out_valid at N+1+MUL_CYCLES.
  - Back-to-back single-cycle ops: throughput 1 per 2 cycles.
- MUL_CYCLES=1: MULS timing is identical to a single-cycle op.
- in_valid while in_ready=0 is ignored; the source must hold its fields.
- alu_control changes only on accept or reset; it is never glitched by input changes outside accept.

Optional Feature:
- Macro ALU_CTRL_STRICT_EN.
- Defined: illegal encodings are not issued. No EXEC, no alu_start, no alu_busy. The block goes straight to DONE with alu_control=0 and illegal=1 (out_valid at N+1).
- Undefined: illegal encodings issue as ADCS (0) through the normal EXEC path, with illegal=1 reported alongside.

Test Plan:
- Reset mid-MULS: assert rst_n=0 during EXEC -> all outputs 0 and state IDLE immediately (async, not waiting for clk).
- ADD (op 10, f7=1, f3=000), out_ready=1 -> alu_start at N+1, out_valid at N+2, alu_control=1, illegal=0.
- MULS (1,011), MUL_CYCLES=3 -> alu_busy cycles N+1..N+4, out_valid at N+4, alu_control=5; in_ready=0 throughout EXEC.
- CMP (1,111) with out_ready=0 for 5 cycles -> out_valid and alu_control=8 held stable; release out_ready with new ORRS (0,110) pending -> ORRS accepted same cycle, alu_control=7 two cycles later.
- Undefined (0,010) and opcode 11 -> illegal=1, alu_control=0. With ALU_CTRL_STRICT_EN: no alu_start pulse and out_valid at N+1. Without it: alu_start pulses.
- Random sequence of 1000 ops with random out_ready -> results match a decode-table model in order, with no drops or duplicates.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_seq
//   Registered, handshaked ALU control decoder. Accepts one decoded field set
//   (opcode/func7/func3) per transaction, produces a registered alu_control
//   code and an illegal flag, and holds the ALU busy for MUL_CYCLES cycles
//   when the operation is MULS.
//
// Parameters
//   CTRL_W      width of alu_control (>= 4), code is zero-extended
//   MUL_CYCLES  cycles MULS occupies the ALU (1..15)
//   CNT_W       width of the internal cycle counter (must hold MUL_CYCLES)
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     input handshake for alu_opcode, func7, func3
//   alu_start               one-cycle pulse in the cycle after accept
//   alu_busy                ALU occupied by the current operation
//   out_valid / out_ready   output handshake for alu_control / illegal
//   alu_control, illegal    registered result of the accepted operation
//
// Optional feature
//   ALU_CTRL_STRICT_EN  when defined, illegal encodings skip the EXEC phase
//                       (no alu_start, no alu_busy) and go straight to DONE.
// -----------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_opcode,
  input  logic              func7,
  input  logic [2:0]        func3,
  output logic              alu_start,
  output logic              alu_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

`ifdef ALU_CTRL_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  // Counter preload for MULS: EXEC lasts MUL_CYCLES-1 extra cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  // Decode table: returns {illegal, code[3:0]}.
  function automatic logic [4:0] decode_f(input logic [1:0] op,
                                          input logic       f7,
                                          input logic [2:0] f3);
    logic [4:0] r;
    r = 5'b1_0000;
    case (op)
      2'b00: r = 5'b0_0000;
      2'b01: r = 5'b0_0001;
      2'b10: begin
        case ({f7, f3})
          4'b0000: r = 5'b0_0000;  // ADCS
          4'b1000: r = 5'b0_0001;  // ADD
          4'b0001: r = 5'b0_0010;  // SBCS
          4'b1001: r = 5'b0_0011;  // SUBS
          4'b1010: r = 5'b0_0100;  // RSBS
          4'b1011: r = 5'b0_0101;  // MULS
          4'b0111: r = 5'b0_0110;  // ANDS
          4'b0110: r = 5'b0_0111;  // ORRS
          4'b1111: r = 5'b0_1000;  // CMP
          default: r = 5'b1_0000;  // undefined R-type
        endcase
      end
      default: r = 5'b1_0000;      // reserved opcode
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic [4:0]         dec_s;
  logic               is_muls_s;
  logic               in_ready_s;
  logic               accept_s;

  assign dec_s     = decode_f(alu_opcode, func7, func3);
  assign is_muls_s = (alu_opcode == 2'b10) && ({func7, func3} == 4'b1011);

  // A finishing result frees the block in the same cycle it is consumed,
  // which is what makes back-to-back issue possible.
  assign in_ready_s = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    start_d   = 1'b0;
    busy_d    = busy_q;
    valid_d   = valid_q;

    if (accept_s) begin
      ctrl_d    = CTRL_W'(dec_s[3:0]);
      illegal_d = dec_s[4];
      if (STRICT && dec_s[4]) begin
        // Illegal op is reported directly without touching the ALU.
        state_d = S_DONE;
        cnt_d   = {CNT_W{1'b0}};
        start_d = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end else begin
        state_d = S_EXEC;
        cnt_d   = is_muls_s ? MUL_LOAD : {CNT_W{1'b0}};
        start_d = 1'b1;
        busy_d  = 1'b1;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_EXEC: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1'b1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      ctrl_q    <= {CTRL_W{1'b0}};
      illegal_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign alu_start   = start_q;
  assign alu_busy    = busy_q;
  assign out_valid   = valid_q;
  assign alu_control = ctrl_q;
  assign illegal     = illegal_q;

endmodule
